// File: rtl/stopwatch_min_sec_if.sv
// Key/tick inputs and BCD display outputs of the MM:SS stopwatch stage.
interface stopwatch_min_sec_if;
  logic       key_ss;
  logic       key_clr;
  logic       key_lap;
  logic       tick;
  logic       run_n;
  logic [3:0] SL;
  logic [3:0] SH;
  logic [3:0] ML;
  logic [3:0] MH;
  logic       ovf;
  logic [1:0] state;
  logic       lap_active;

  modport master (
    output key_ss, key_clr, key_lap, tick,
    input  run_n, SL, SH, ML, MH, ovf, state, lap_active
  );

  modport slave (
    input  key_ss, key_clr, key_lap, tick,
    output run_n, SL, SH, ML, MH, ovf, state, lap_active
  );
endinterface

// File: rtl/stopwatch_min_sec.sv
// MM:SS BCD accumulator and start/stop/clear FSM fed by the sub-second carry.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
module stopwatch_min_sec #(
  parameter int MIN_MAX     = 59,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  stopwatch_min_sec_if.slave sw
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  localparam logic [3:0] MIN_ML = 4'(MIN_MAX % 10);
  localparam logic [3:0] MIN_MH = 4'(MIN_MAX / 10);

  localparam int K_SS  = 0;
  localparam int K_CLR = 1;
  localparam int K_LAP = 2;

  typedef struct packed {
    logic [3:0] mh;
    logic [3:0] ml;
    logic [3:0] sh;
    logic [3:0] sl;
  } bcd_t;

  // ---------------------------------------------------------------- keys
  logic [2:0]                  key_raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  key_last_q;
  logic [2:0]                  key_sync;
  logic [2:0]                  key_edge;

  assign key_raw = {sw.key_lap, sw.key_clr, sw.key_ss};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      key_last_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i]     <= {sync_q[i][SYNC_STAGES-2:0], key_raw[i]};
        key_last_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    key_sync = '0;
    for (int i = 0; i < 3; i++) key_sync[i] = sync_q[i][SYNC_STAGES-1];
  end

  assign key_edge = key_sync & ~key_last_q;

  logic ss_edge, clr_edge;
  assign ss_edge  = key_edge[K_SS];
  assign clr_edge = key_edge[K_CLR];

  // ---------------------------------------------------------------- FSM
  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_edge) state_d = S_RUN;
      S_RUN:   if (ss_edge) state_d = S_PAUSE;
      S_PAUSE: begin
        if (clr_edge)     state_d = S_IDLE;
        else if (ss_edge) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------- count
  // Edge of co, not level: the upstream counter holds co while stopped.
  logic tick_q;
  logic cnt_en, clr_cnt;
  bcd_t cnt_q, cnt_d;
  logic ovf_q, ovf_d;

  assign cnt_en  = sw.tick & ~tick_q & (state_q == S_RUN);
  assign clr_cnt = clr_edge & (state_q == S_PAUSE);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      if (cnt_q.sl != 4'd9) begin
        cnt_d.sl = cnt_q.sl + 4'd1;
      end else begin
        cnt_d.sl = 4'd0;
        if (cnt_q.sh != 4'd5) begin
          cnt_d.sh = cnt_q.sh + 4'd1;
        end else begin
          cnt_d.sh = 4'd0;
          if (cnt_q.ml == MIN_ML && cnt_q.mh == MIN_MH) begin
            cnt_d.ml = 4'd0;
            cnt_d.mh = 4'd0;
            ovf_d    = 1'b1;
          end else if (cnt_q.ml == 4'd9) begin
            cnt_d.ml = 4'd0;
            cnt_d.mh = cnt_q.mh + 4'd1;
          end else begin
            cnt_d.ml = cnt_q.ml + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= sw.tick;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------------------------------------------------------- lap
  bcd_t disp;

`ifdef LAP_HOLD_EN
  logic lap_edge;
  logic lap_q, lap_d;
  bcd_t cap_q, cap_d;

  assign lap_edge = key_edge[K_LAP];

  // Capture the pre-increment count so a same-cycle tick lands in the live count only.
  always_comb begin
    lap_d = lap_q;
    cap_d = cap_q;
    if (clr_edge) begin
      lap_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (ss_edge) begin
        lap_d = 1'b0;
      end else if (lap_edge) begin
        lap_d = ~lap_q;
        if (!lap_q) cap_d = cnt_q;
      end
    end else begin
      lap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q <= 1'b0;
      cap_q <= '0;
    end else begin
      lap_q <= lap_d;
      cap_q <= cap_d;
    end
  end

  assign disp          = lap_q ? cap_q : cnt_q;
  assign sw.lap_active = lap_q;
`else
  logic lap_edge_unused;
  assign lap_edge_unused = key_edge[K_LAP];
  assign disp            = cnt_q;
  assign sw.lap_active   = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  assign sw.run_n = (state_q != S_RUN);
  assign sw.state = state_q;
  assign sw.ovf   = ovf_q;
  assign sw.SL    = disp.sl;
  assign sw.SH    = disp.sh;
  assign sw.ML    = disp.ml;
  assign sw.MH    = disp.mh;

endmodule

// File: tb/tb_stopwatch_min_sec.sv
// Directed bench for stopwatch_min_sec: FSM timing, BCD carries, wrap, tick edge use, reset, lap.
module tb_stopwatch_min_sec;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  stopwatch_min_sec_if swif();

  stopwatch_min_sec #(.MIN_MAX(59), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (swif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] disp;
  assign disp = {swif.MH, swif.ML, swif.SH, swif.SL};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Keys change right after a negedge; after 3 negedges the FSM edge has happened.
  task automatic press(input logic ss, input logic clr, input logic lap);
    swif.key_ss  = ss;
    swif.key_clr = clr;
    swif.key_lap = lap;
    step(3);
    swif.key_ss  = 1'b0;
    swif.key_clr = 1'b0;
    swif.key_lap = 1'b0;
    step(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      swif.tick = 1'b1;
      step(1);
      swif.tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset        = 1'b0;
    swif.key_ss  = 1'b0;
    swif.key_clr = 1'b0;
    swif.key_lap = 1'b0;
    swif.tick    = 1'b0;
    step(2);

    // reset values
    chk("rst_state", {14'd0, swif.state}, 16'h0000);
    chk("rst_run_n", {15'd0, swif.run_n}, 16'h0001);
    chk("rst_digits", disp, 16'h0000);
    chk("rst_ovf", {15'd0, swif.ovf}, 16'h0000);
    chk("rst_lap", {15'd0, swif.lap_active}, 16'h0000);
    reset = 1'b1;
    step(2);

    // start: key high before edge k, state changes at edge k+2
    swif.key_ss = 1'b1;
    step(1);
    chk("start_k0_state", {14'd0, swif.state}, 16'h0000);
    step(1);
    chk("start_k1_state", {14'd0, swif.state}, 16'h0000);
    chk("start_k1_run_n", {15'd0, swif.run_n}, 16'h0001);
    chk("start_k1_digits", disp, 16'h0000);
    chk("start_k1_ovf", {15'd0, swif.ovf}, 16'h0000);
    step(1);
    chk("start_k2_state", {14'd0, swif.state}, 16'h0001);
    chk("start_k2_run_n", {15'd0, swif.run_n}, 16'h0000);
    swif.key_ss = 1'b0;
    step(3);

    // BCD carries
    ticks(10);
    chk("ten_ticks", disp, 16'h0010);
    ticks(60);
    chk("seventy_ticks", disp, 16'h0110);

    // up to 59:59 then wrap
    ticks(3529);
    chk("at_5959", disp, 16'h5959);
    chk("ovf_before_wrap", {15'd0, swif.ovf}, 16'h0000);
    swif.tick = 1'b1;
    step(1);
    swif.tick = 1'b0;
    chk("wrap_digits", disp, 16'h0000);
    chk("wrap_ovf_hi", {15'd0, swif.ovf}, 16'h0001);
    step(1);
    chk("wrap_ovf_lo", {15'd0, swif.ovf}, 16'h0000);
    chk("wrap_still_run", {14'd0, swif.state}, 16'h0001);
    step(1);

    // held tick counts once
    swif.tick = 1'b1;
    step(20);
    swif.tick = 1'b0;
    step(1);
    chk("held_tick", disp, 16'h0001);

    // pause discards ticks
    press(1'b1, 1'b0, 1'b0);
    chk("pause_state", {14'd0, swif.state}, 16'h0002);
    chk("pause_run_n", {15'd0, swif.run_n}, 16'h0001);
    ticks(5);
    chk("pause_no_count", disp, 16'h0001);

    // resume to 03:27, pause, ss+clr together -> IDLE and cleared
    press(1'b1, 1'b0, 1'b0);
    chk("resume_state", {14'd0, swif.state}, 16'h0001);
    ticks(206);
    chk("at_0327", disp, 16'h0327);
    press(1'b1, 1'b0, 1'b0);
    chk("pause2_state", {14'd0, swif.state}, 16'h0002);
    press(1'b1, 1'b1, 1'b0);
    chk("clr_wins_state", {14'd0, swif.state}, 16'h0000);
    chk("clr_digits", disp, 16'h0000);

    // clr ignored in IDLE and RUN
    press(1'b0, 1'b1, 1'b0);
    chk("idle_clr_ignored", {14'd0, swif.state}, 16'h0000);
    press(1'b1, 1'b0, 1'b0);
    ticks(3);
    press(1'b0, 1'b1, 1'b0);
    chk("run_clr_state", {14'd0, swif.state}, 16'h0001);
    chk("run_clr_digits", disp, 16'h0003);

    // asynchronous reset mid-RUN, checked between clock edges
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", {14'd0, swif.state}, 16'h0000);
    chk("async_rst_run_n", {15'd0, swif.run_n}, 16'h0001);
    chk("async_rst_digits", disp, 16'h0000);

    // key held through reset gives exactly one edge
    swif.key_ss = 1'b1;
    step(2);
    reset = 1'b1;
    step(3);
    chk("held_key_start", {14'd0, swif.state}, 16'h0001);
    step(5);
    chk("held_key_once", {14'd0, swif.state}, 16'h0001);
    swif.key_ss = 1'b0;
    step(2);

    // lap hold
    ticks(5);
    chk("pre_lap", disp, 16'h0005);
    press(1'b0, 1'b0, 1'b1);
`ifdef LAP_HOLD_EN
    chk("lap_set", {15'd0, swif.lap_active}, 16'h0001);
    ticks(3);
    chk("lap_frozen", disp, 16'h0005);
    chk("lap_still_set", {15'd0, swif.lap_active}, 16'h0001);
    press(1'b0, 1'b0, 1'b1);
    chk("lap_release", {15'd0, swif.lap_active}, 16'h0000);
    chk("lap_live", disp, 16'h0008);
`else
    chk("lap_ignored", {15'd0, swif.lap_active}, 16'h0000);
    ticks(3);
    chk("lap_live_count", disp, 16'h0008);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
